// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM states, the default data-memory limit and the request error check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  localparam logic [31:0] LSU_DMEM_LIMIT_DEFAULT = 32'h003F_FFFF;

  // A request is rejected when its size is illegal, it is not naturally
  // aligned, or it reaches past the last legal byte of data memory.
  function automatic logic lsu_req_error(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [31:0] limit);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = (addr[1:0] != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad || (addr > limit);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Replicate store data across lanes and pick the lanes to enable.
  always_comb begin
    wdata_lanes = 32'h0000_0000;
    byte_en     = 4'b0000;
    case (size)
      SIZE_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        byte_en     = 4'b0001 << lane;
      end
      SIZE_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        wdata_lanes = wdata;
        byte_en     = 4'b1111;
      end
      default: begin
        wdata_lanes = 32'h0000_0000;
        byte_en     = 4'b0000;
      end
    endcase
  end

  // Select the addressed byte and halfword out of the read word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected field to 32 bits.
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SIZE_BYTE: load_data = load_unsigned ? {24'h00_0000, byte_s}
                                           : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: load_data = load_unsigned ? {16'h0000, half_s}
                                           : {{16{half_s[15]}}, half_s};
      SIZE_WORD: load_data = rdata;
      default:   load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request, performs a single-cycle memory
// access, then presents a response held until the CPU takes it.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_LIMIT = LSU_DMEM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  lsu_state_e  state_r;
  lsu_state_e  state_s;
  logic        req_ready_s;
  logic        accept_s;

  logic        we_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        err_r;

  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic [31:0] wdata_lanes_s;
  logic [3:0]  byte_en_s;
  logic [31:0] load_data_s;
  logic [3:0]  dwe_s;

  lsu_lane_align u_align (
    .size          (size_r),
    .load_unsigned (unsigned_r),
    .lane          (addr_r[1:0]),
    .wdata         (wdata_r),
    .rdata         (drdata),
    .wdata_lanes   (wdata_lanes_s),
    .byte_en       (byte_en_s),
    .load_data     (load_data_s)
  );

  // Ready when idle, or when the pending response is being taken this cycle.
  always_comb begin
    req_ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      req_ready_s = 1'b1;
    end else if (state_r == ST_RESP) begin
      req_ready_s = rsp_ready;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign accept_s = req_valid && req_ready_s;

  // Next-state logic; ACCESS always lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = accept_s ? ST_ACCESS : ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, request capture and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        we_r       <= req_we;
        size_r     <= req_size;
        unsigned_r <= req_unsigned;
        addr_r     <= req_addr;
        wdata_r    <= req_wdata;
        err_r      <= lsu_req_error(req_size, req_addr, DMEM_LIMIT);
      end
      if (state_r == ST_ACCESS) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= err_r;
        rsp_rdata_r <= (we_r || err_r) ? 32'h0000_0000 : load_data_s;
      end else if ((state_r == ST_RESP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Write enables only for a clean store in ACCESS, gated by reset directly
  // so a reset landing mid-access cannot corrupt memory.
  always_comb begin
    dwe_s = 4'b0000;
    if (reset && (state_r == ST_ACCESS) && we_r && !err_r) begin
      dwe_s = byte_en_s;
    end else begin
      dwe_s = 4'b0000;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign daddr     = {addr_r[31:2], 2'b00};
  assign dwdata    = wdata_lanes_s;
  assign dwe       = dwe_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-level
// reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  logic [31:0] dmem [0:15];
  logic [7:0]  ref_bytes [0:63];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .daddr        (daddr),
    .dwdata       (dwdata),
    .dwe          (dwe),
    .drdata       (drdata)
  );

  // Memory seen by the DUT: asynchronous read, byte-enabled write.
  assign drdata = dmem[daddr[5:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dwe[i]) dmem[daddr[5:2]][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if ((addr % nbytes(size)) != 0) return 1'b1;
    return addr > 32'h003F_FFFF;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    longint unsigned v = 0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v += longint'(ref_bytes[(addr + i) % 64]) << (8 * i);
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w = wdata;
    for (int i = 0; i < nbytes(size); i++) ref_bytes[(addr + i) % 64] = w[8*i +: 8];
  endtask

  // One complete request/response, checking memory-side and CPU-side behaviour.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] got);
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_rd;
    logic [31:0] e_dw;
    e_err = model_err(size, addr);
    e_be  = 4'b0000;
    if (we && !e_err)
      for (int i = 0; i < nbytes(size); i++) e_be[(addr % 4) + i] = 1'b1;
    e_rd = (we || e_err) ? 32'h0 : model_load(size, uns, addr);
    e_dw = (size == 2'd0) ? wdata[7:0] * 32'h0101_0101 :
           (size == 2'd1) ? wdata[15:0] * 32'h0001_0001 : wdata;
    @(negedge clk);
    check({tag, "_idle_dwe"}, {28'h0, dwe}, 32'h0);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_acc_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_dwe"}, {28'h0, dwe}, {28'h0, e_be});
    check({tag, "_daddr"}, daddr, addr & 32'hFFFF_FFFC);
    if (we && !e_err) check({tag, "_dwdata"}, dwdata, e_dw);
    @(posedge clk);
    if (we && !e_err) model_store(size, addr, wdata);
    @(negedge clk);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_rsp_err"}, {31'h0, rsp_err}, {31'h0, e_err});
    check({tag, "_rsp_rdata"}, rsp_rdata, e_rd);
    check({tag, "_resp_dwe"}, {28'h0, dwe}, 32'h0);
    got = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] e_thr;
    logic [31:0] wd;
    int cnt;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dwdata", dwdata, 32'h0);
    check("rst_dwe", {28'h0, dwe}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b1;

    // Fill memory through the DUT so both memories start identical.
    for (int i = 0; i < 16; i++) run_txn(1'b1, 2'd2, 1'b0, 32'h100 + 4 * i, $urandom, "init", got);

    // Store byte 0xA5 to 0x13.
    run_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, "st_byte", got);
    check("st_byte_word", dmem[4], ref_word(4));
    check("st_byte_lane3", {24'h0, dmem[4][31:24]}, 32'hA5);

    // Signed / unsigned halfword loads from a known word.
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01, "st_word", got);
    run_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "ld_half_s", got);
    check("ld_half_s_const", got, 32'hFFFF_80FF);
    run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "ld_half_u", got);
    check("ld_half_u_const", got, 32'h0000_80FF);

    // Error cases and the memory limit boundary.
    run_txn(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, "ld_word_mis", got);
    run_txn(1'b1, 2'd2, 1'b0, 32'h0040_0000, 32'hDEAD_BEEF, "st_oor", got);
    check("st_oor_mem", dmem[0], ref_word(0));
    run_txn(1'b1, 2'd2, 1'b0, 32'h003F_FFFC, 32'h1234_5678, "st_limit", got);
    run_txn(1'b0, 2'd0, 1'b0, 32'h003F_FFFF, 32'h0, "ld_limit", got);
    run_txn(1'b0, 2'd1, 1'b1, 32'h0040_0000, 32'h0, "ld_oor", got);
    run_txn(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, "st_ill", got);
    run_txn(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF, "st_half_mis", got);

    // Random traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 7) == 0) ? 32'h0040_0000 + $urandom_range(0, 63)
                                      : 32'h100 + $urandom_range(0, 63);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, "rand", got);
    end

    // Back-to-back loads with rsp_ready held high: one response every 2 cycles.
    e_thr = model_load(2'd2, 1'b0, 32'h120);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h120; rsp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cnt++;
        check("b2b_rdata", rsp_rdata, e_thr);
      end
    end
    check("b2b_count", cnt, 32'd6);
    // Stall for 3 cycles: response held, no new request taken.
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rdata", rsp_rdata, e_thr);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {31'h0, rsp_valid}, 32'h0);
    rsp_ready = 1'b0;

    // Reset during the ACCESS cycle of a word store.
    wd = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h124; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstacc_dwe_before", {28'h0, dwe}, 32'hF);
    reset = 1'b0;
    #1 check("rstacc_dwe_gated", {28'h0, dwe}, 32'h0);
    @(negedge clk);
    check("rstacc_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rstacc_daddr", daddr, 32'h0);
    check("rstacc_dwdata", dwdata, 32'h0);
    check("rstacc_mem", dmem[9], ref_word(9));
    reset = 1'b1;
    run_txn(1'b0, 2'd2, 1'b1, 32'h124, 32'h0, "post_rst_ld", got);

    // Final sweep: DUT-written memory must equal the reference.
    for (int i = 0; i < 16; i++) check("final_mem", dmem[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
